// File: rtl/bus_responder.sv
// bus_responder: answers memory/register requests from the fetcher and
// execution units. Register selections (X, Y) answer in one cycle; memory
// selections go through a wait-stated RAM port.
// Optional feature macro: RAM_MIRROR_EN folds 0x0800-0x1FFF onto 0x0000-0x07FF.

`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef SELECTOR_MEM
`define SELECTOR_MEM 4'h0
`endif
`ifndef SELECTOR_X
`define SELECTOR_X 4'h1
`endif
`ifndef SELECTOR_Y
`define SELECTOR_Y 4'h2
`endif

module bus_responder #(
    parameter int REG_WIDTH  = `REG_WIDTH,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int MEM_WAIT   = 0
) (
    input  logic                  phi1,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [3:0]            fetch_selector,
    input  logic [REG_WIDTH-1:0]  wdata,
    input  logic [REG_WIDTH-1:0]  reg_x,
    input  logic [REG_WIDTH-1:0]  reg_y,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]  mem_wdata,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [REG_WIDTH-1:0]  data_out,
    output logic                  data_valid,
    output logic                  wr_done,
    output logic                  busy,
    output logic                  sel_err
);

    localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                  state_q;
    logic [2:0]              waitCnt_q;
    logic [ADDR_WIDTH-1:0]   memAddr_q;
    logic [REG_WIDTH-1:0]    memWdata_q;
    logic                    memRe_q;
    logic                    memWe_q;
    logic [REG_WIDTH-1:0]    dataOut_q;
    logic                    dataValid_q;
    logic                    wrDone_q;
    logic                    busy_q;
    logic                    selErr_q;
    logic [ADDR_WIDTH-1:0]   mappedAddr_d;

    // Translate the request address into the RAM address (mirror folding when enabled).
    always_comb begin
        mappedAddr_d = addr;
`ifdef RAM_MIRROR_EN
        if (addr < ADDR_WIDTH'(32'h2000)) begin
            mappedAddr_d        = '0;
            mappedAddr_d[10:0]  = addr[10:0];
        end
`endif
    end

    // Request FSM: decodes selectors in IDLE, counts wait states in ACCESS, all outputs registered.
    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            waitCnt_q   <= '0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            memRe_q     <= 1'b0;
            memWe_q     <= 1'b0;
            dataOut_q   <= '0;
            dataValid_q <= 1'b0;
            wrDone_q    <= 1'b0;
            busy_q      <= 1'b0;
            selErr_q    <= 1'b0;
        end else begin
            dataValid_q <= 1'b0;
            wrDone_q    <= 1'b0;
            selErr_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        case (fetch_selector)
                            `SELECTOR_X: begin
                                dataOut_q   <= reg_x;
                                dataValid_q <= 1'b1;
                            end
                            `SELECTOR_Y: begin
                                dataOut_q   <= reg_y;
                                dataValid_q <= 1'b1;
                            end
                            `SELECTOR_MEM: begin
                                memAddr_q <= mappedAddr_d;
                                busy_q    <= 1'b1;
                                waitCnt_q <= WAIT_INIT;
                                state_q   <= ACCESS;
                                if (we) begin
                                    memWe_q    <= 1'b1;
                                    memWdata_q <= wdata;
                                end else begin
                                    memRe_q <= 1'b1;
                                end
                            end
                            default: begin
                                dataOut_q   <= '0;
                                dataValid_q <= 1'b1;
                                selErr_q    <= 1'b1;
                            end
                        endcase
                    end
                end
                ACCESS: begin
                    if (waitCnt_q != 3'd0) begin
                        waitCnt_q <= waitCnt_q - 3'd1;
                    end else begin
                        if (memWe_q) begin
                            wrDone_q <= 1'b1;
                        end else begin
                            dataOut_q   <= mem_rdata;
                            dataValid_q <= 1'b1;
                        end
                        memRe_q <= 1'b0;
                        memWe_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign mem_addr   = memAddr_q;
    assign mem_wdata  = memWdata_q;
    assign mem_re     = memRe_q;
    assign mem_we     = memWe_q;
    assign data_out   = dataOut_q;
    assign data_valid = dataValid_q;
    assign wr_done    = wrDone_q;
    assign busy       = busy_q;
    assign sel_err    = selErr_q;

endmodule

// File: tb/tb_bus_responder.sv
// Testbench for bus_responder: directed scenarios plus randomized requests,
// checked every cycle against a transaction-level reference model.

`ifndef SELECTOR_MEM
`define SELECTOR_MEM 4'h0
`endif
`ifndef SELECTOR_X
`define SELECTOR_X 4'h1
`endif
`ifndef SELECTOR_Y
`define SELECTOR_Y 4'h2
`endif

module tb_bus_responder;

    localparam int WAIT = 2;

    logic        phi1 = 1'b0;
    logic        reset_n = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [3:0]  fetch_selector = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  reg_x = '0;
    logic [7:0]  reg_y = '0;
    logic [7:0]  mem_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        wr_done;
    logic        busy;
    logic        sel_err;

    // RAM attached to the DUT, and the model's own view of what RAM should hold
    logic [7:0] ram    [0:65535];
    logic [7:0] refRam [0:65535];

    int testCount = 0;
    int failCount = 0;

    // Model state: access timestamps instead of counters
    int          edgeNo;
    int          doneEdge;
    bit          inAccess;
    bit          accIsWrite;
    logic [15:0] expMemAddr;
    logic [7:0]  expMemWdata;
    logic        expRe, expWe, expBusy, expValid, expDone, expErr;
    logic [7:0]  expData;

    bus_responder #(
        .REG_WIDTH(8),
        .ADDR_WIDTH(16),
        .MEM_WAIT(WAIT)
    ) dut (
        .phi1(phi1),
        .reset_n(reset_n),
        .req(req),
        .we(we),
        .addr(addr),
        .fetch_selector(fetch_selector),
        .wdata(wdata),
        .reg_x(reg_x),
        .reg_y(reg_y),
        .mem_rdata(mem_rdata),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_re(mem_re),
        .mem_we(mem_we),
        .data_out(data_out),
        .data_valid(data_valid),
        .wr_done(wr_done),
        .busy(busy),
        .sel_err(sel_err)
    );

    initial forever #5 phi1 = ~phi1;

    assign mem_rdata = ram[mem_addr];

    always @(posedge phi1) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    initial begin
        #1000000;
        failCount++;
        $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, observed, expected, edgeNo);
        end
    endtask

    function automatic logic [15:0] mapAddr(input logic [15:0] a);
`ifdef RAM_MIRROR_EN
        if (a >= 16'h0800 && a <= 16'h1FFF) return a - (a & 16'hF800);
`endif
        return a;
    endfunction

    task automatic modelReset();
        edgeNo      = 0;
        doneEdge    = -1;
        inAccess    = 1'b0;
        accIsWrite  = 1'b0;
        expMemAddr  = '0;
        expMemWdata = '0;
        expRe       = 1'b0;
        expWe       = 1'b0;
        expBusy     = 1'b0;
        expValid    = 1'b0;
        expDone     = 1'b0;
        expErr      = 1'b0;
        expData     = '0;
    endtask

    // Predict what the outputs must look like after the coming edge
    task automatic modelEdge(input bit r, input bit w, input logic [3:0] sel,
                             input logic [15:0] a, input logic [7:0] wd,
                             input logic [7:0] x, input logic [7:0] y);
        edgeNo++;
        expValid = 1'b0;
        expDone  = 1'b0;
        expErr   = 1'b0;
        if (inAccess) begin
            if (edgeNo == doneEdge) begin
                inAccess = 1'b0;
                expRe    = 1'b0;
                expWe    = 1'b0;
                expBusy  = 1'b0;
                if (accIsWrite) begin
                    expDone = 1'b1;
                    refRam[expMemAddr] = expMemWdata;
                end else begin
                    expData  = refRam[expMemAddr];
                    expValid = 1'b1;
                end
            end
        end else if (r) begin
            if (sel == `SELECTOR_X) begin
                expData  = x;
                expValid = 1'b1;
            end else if (sel == `SELECTOR_Y) begin
                expData  = y;
                expValid = 1'b1;
            end else if (sel == `SELECTOR_MEM) begin
                inAccess   = 1'b1;
                accIsWrite = w;
                doneEdge   = edgeNo + 1 + WAIT;
                expMemAddr = mapAddr(a);
                expBusy    = 1'b1;
                if (w) begin
                    expWe       = 1'b1;
                    expMemWdata = wd;
                end else begin
                    expRe = 1'b1;
                end
            end else begin
                expData  = 8'h00;
                expValid = 1'b1;
                expErr   = 1'b1;
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("data_out",   32'(data_out),   32'(expData));
        checkOutput("data_valid", 32'(data_valid), 32'(expValid));
        checkOutput("wr_done",    32'(wr_done),    32'(expDone));
        checkOutput("sel_err",    32'(sel_err),    32'(expErr));
        checkOutput("busy",       32'(busy),       32'(expBusy));
        checkOutput("mem_re",     32'(mem_re),     32'(expRe));
        checkOutput("mem_we",     32'(mem_we),     32'(expWe));
        checkOutput("mem_addr",   32'(mem_addr),   32'(expMemAddr));
        checkOutput("mem_wdata",  32'(mem_wdata),  32'(expMemWdata));
    endtask

    task automatic applyStimulus(input bit r, input bit w, input logic [3:0] sel,
                                 input logic [15:0] a, input logic [7:0] wd,
                                 input logic [7:0] x, input logic [7:0] y);
        @(negedge phi1);
        req            = r;
        we             = w;
        fetch_selector = sel;
        addr           = a;
        wdata          = wd;
        reg_x          = x;
        reg_y          = y;
        modelEdge(r, w, sel, a, wd, x, y);
        @(posedge phi1);
        #1;
        compareAll();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'($urandom), 4'($urandom), 16'($urandom),
                          8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    function automatic logic [3:0] pickSelector();
        int k;
        logic [3:0] s;
        k = $urandom_range(0, 9);
        if (k < 4) return `SELECTOR_MEM;
        if (k < 6) return `SELECTOR_X;
        if (k < 8) return `SELECTOR_Y;
        s = 4'($urandom);
        while (s == `SELECTOR_MEM || s == `SELECTOR_X || s == `SELECTOR_Y)
            s = 4'($urandom);
        return s;
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i]    = 8'($urandom);
            refRam[i] = ram[i];
        end

        // Asynchronous reset: all outputs zero before any clock edge
        #2;
        reset_n = 1'b0;
        #1;
        modelReset();
        compareAll();
        @(negedge phi1);
        @(negedge phi1);
        reset_n = 1'b1;

        // Register read, then hold with no request
        applyStimulus(1'b1, 1'b1, `SELECTOR_X, 16'h0000, 8'h00, 8'h5A, 8'h11);
        idleCycles(2);

        // RAM read with wait states; a second request while busy is dropped
        ram[16'h0123]    = 8'hC3;
        refRam[16'h0123] = 8'hC3;
        applyStimulus(1'b1, 1'b0, `SELECTOR_MEM, 16'h0123, 8'h00, 8'h01, 8'h02);
        applyStimulus(1'b1, 1'b0, `SELECTOR_Y, 16'h0000, 8'h00, 8'h01, 8'h99);
        idleCycles(3);

        // Write then read back the same location
        applyStimulus(1'b1, 1'b1, `SELECTOR_MEM, 16'h0200, 8'h77, 8'h00, 8'h00);
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, `SELECTOR_MEM, 16'h0200, 8'h00, 8'h00, 8'h00);
        idleCycles(3);

        // Unsupported selector, then back-to-back register requests
        applyStimulus(1'b1, 1'b0, 4'hF, 16'h0000, 8'h00, 8'h33, 8'h44);
        applyStimulus(1'b1, 1'b0, `SELECTOR_X, 16'h0000, 8'h00, 8'hA1, 8'hB2);
        applyStimulus(1'b1, 1'b0, `SELECTOR_Y, 16'h0000, 8'h00, 8'hA1, 8'hB2);
        applyStimulus(1'b1, 1'b0, `SELECTOR_X, 16'h0000, 8'h00, 8'hC4, 8'hD5);

        // Request arriving on the completion edge is ignored
        applyStimulus(1'b1, 1'b0, `SELECTOR_MEM, 16'h0042, 8'h00, 8'h00, 8'h00);
        idleCycles(2);
        applyStimulus(1'b1, 1'b0, `SELECTOR_X, 16'h0000, 8'h00, 8'hEE, 8'h00);
        idleCycles(1);

        // Mirror window boundaries
        applyStimulus(1'b1, 1'b0, `SELECTOR_MEM, 16'h1805, 8'h00, 8'h00, 8'h00);
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, `SELECTOR_MEM, 16'h2002, 8'h00, 8'h00, 8'h00);
        idleCycles(3);
        applyStimulus(1'b1, 1'b1, `SELECTOR_MEM, 16'h0805, 8'h6B, 8'h00, 8'h00);
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, `SELECTOR_MEM, 16'h0005, 8'h00, 8'h00, 8'h00);
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, `SELECTOR_MEM, 16'h07FF, 8'h00, 8'h00, 8'h00);
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, `SELECTOR_MEM, 16'h1FFF, 8'h00, 8'h00, 8'h00);
        idleCycles(3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 16'h27FF)) : 16'($urandom);
            applyStimulus(($urandom_range(0, 9) < 7), 1'($urandom), pickSelector(), a,
                          8'($urandom), 8'($urandom), 8'($urandom));
        end
        idleCycles(4);

        // Reset in the middle of a RAM read aborts it with no pulse afterwards
        applyStimulus(1'b1, 1'b0, `SELECTOR_X, 16'h0000, 8'h00, 8'h5A, 8'h00);
        applyStimulus(1'b1, 1'b0, `SELECTOR_MEM, 16'h0300, 8'h00, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b0, `SELECTOR_MEM, 16'h0000, 8'h00, 8'h00, 8'h00);
        @(negedge phi1);
        req = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        modelReset();
        compareAll();
        @(posedge phi1);
        #1;
        compareAll();
        @(negedge phi1);
        reset_n = 1'b1;
        idleCycles(6);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Serves the memory/register read and write requests issued by the instruction fetcher and execution units: the responder end of the addr / fetch_selector / data_in interface.
- Decodes the selector and returns the value on data_out, which feeds the requester's data_in.
- Memory selections go through a wait-stated RAM port; register selections (X, Y) are answered in one cycle.
- Sits between the CPU core and the system RAM.

Parameters:
- REG_WIDTH, `REG_WIDTH, data/register width (8).
- ADDR_WIDTH, `ADDR_WIDTH, address width (16).
- MEM_WAIT, 0, extra wait cycles per RAM access (0..7).

Ports:
- phi1  input  1  clock; all state updates on posedge phi1.
- reset_n  input  1  asynchronous active-low reset.
- req  input  1  request strobe, sampled on posedge phi1.
- we  input  1  1 = write, 0 = read; meaningful only with `SELECTOR_MEM.
- addr  input  ADDR_WIDTH  request address.
- fetch_selector  input  4  source select: `SELECTOR_MEM, `SELECTOR_X, `SELECTOR_Y.
- wdata  input  REG_WIDTH  write data.
- reg_x  input  REG_WIDTH  current X register.
- reg_y  input  REG_WIDTH  current Y register.
- mem_rdata  input  REG_WIDTH  RAM read data.
- mem_addr  output  ADDR_WIDTH  RAM address.
- mem_wdata  output  REG_WIDTH  RAM write data.
- mem_re  output  1  RAM read enable.
- mem_we  output  1  RAM write enable.
- data_out  output  REG_WIDTH  response data (to requester data_in).
- data_valid  output  1  one-cycle pulse: data_out updated.
- wr_done  output  1  one-cycle pulse: write complete.
- busy  output  1  RAM access in progress; requests ignored.
- sel_err  output  1  one-cycle pulse: unsupported selector.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; wait counter=0.
  - All outputs go to 0: mem_addr, mem_wdata, mem_re, mem_we, data_out, data_valid, wr_done, busy, sel_err.
  - Any in-flight access is aborted immediately; no valid or done pulse is issued for it.
- States: IDLE, ACCESS.
- IDLE, req=1 at edge N, by selector:
  - `SELECTOR_X or `SELECTOR_Y: after edge N, data_out = reg_x / reg_y sampled at N and data_valid=1. Stay IDLE. we is ignored. Latency 1.
  - `SELECTOR_MEM, we=0: after N, mem_addr=addr (mapped, see Optional Feature), mem_re=1, busy=1, counter=MEM_WAIT. Go ACCESS.
  - `SELECTOR_MEM, we=1: same, but mem_we=1 and mem_wdata=wdata instead of mem_re.
  - Any other selector: after N, data_out=0x00, data_valid=1, sel_err=1. Stay IDLE.
- ACCESS:
  - mem_addr, mem_wdata, mem_re, mem_we and busy are held stable.
  - Each edge with counter!=0: counter decrements.
  - Edge with counter==0:
    - Read: data_out=mem_rdata, data_valid=1.
    - Write: wr_done=1; data_out unchanged.
    - mem_re, mem_we and busy clear. Return to IDLE.
  - Total latency from request edge N: result after edge N+1+MEM_WAIT. With MEM_WAIT=0, result after N+1.
  - RAM enables are asserted for exactly MEM_WAIT+1 cycles.
- Pulses: data_valid, wr_done and sel_err are high for exactly one cycle and default to 0 on every other edge.
- req while busy=1 (ACCESS): ignored, not queued. The requester must hold or re-issue the request after busy falls.
- req in the same edge that ACCESS completes: ignored. The next request is accepted no earlier than the following edge.
- data_out holds its last value between pulses (open-bus behaviour).
- Back-to-back register requests are each answered on consecutive cycles.

Optional Feature:
- Macro: RAM_MIRROR_EN.
- Defined:
  - Addresses 0x0800–0x1FFF are folded onto 0x0000–0x07FF (mem_addr = {5'b0, addr[10:0]}).
  - Addresses >= 0x2000 pass unchanged.
  - Applies to both reads and writes.
- Undefined: mem_addr = addr for all addresses.

Test Plan:
- Reset: assert reset_n=0 mid-ACCESS (MEM_WAIT=3) -> mem_re, busy and data_out drop to 0 at once; no data_valid pulse afterwards.
- Register read: reg_x=0x5A, req with `SELECTOR_X -> one edge later data_out=0x5A, data_valid=1 for one cycle, busy never set.
- RAM read, MEM_WAIT=2: mem_rdata=0xC3, addr=0x0123 -> mem_re high 3 cycles with mem_addr=0x0123; data_out=0xC3 and data_valid after edge N+3.
- RAM write then read-back, MEM_WAIT=0: write 0x77 to 0x0200 -> mem_we high 1 cycle, wr_done pulse. Then read 0x0200 returns 0x77 from the RAM model.
- Busy drop: second req during ACCESS -> ignored, exactly one data_valid. Unsupported selector 4'hF -> data_out=0x00, sel_err pulse.
- RAM_MIRROR_EN: read 0x1805 -> mem_addr=0x0005. Read 0x2002 -> mem_addr=0x2002. Without the macro, 0x1805 passes unchanged.
